seq_divider: RTL and testbench

//  Sequential restoring divider: 2*DW-bit dividend / DW-bit divisor -> DW-bit quotient + DW-bit remainder.

---
 rtl/div_pkg.sv | 13 +
 rtl/seq_divider_step.sv | 23 ++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential restoring divider.
package div_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int CNT_W_DEFAULT = $clog2(DW_DEFAULT + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int DW = 8
) (
    input  logic [DW-1:0] r_in,
    input  logic          bit_in,
    input  logic [DW-1:0] d_in,
    output logic [DW-1:0] r_next,
    output logic          qbit
);

    logic [DW:0] trial;
    logic [DW:0] diff;

    // The compare is one bit wider than the remainder so that a divisor near 2^DW still resolves.
    always_comb begin
        trial  = {r_in, bit_in};
        diff   = trial - {1'b0, d_in};
        qbit   = (trial >= {1'b0, d_in});
        r_next = qbit ? diff[DW-1:0] : trial[DW-1:0];
    end

endmodule

// File: rtl/seq_divider.sv
// 2*DW by DW unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_divider
    import div_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2*DW-1:0] dividend,
    input  logic [DW-1:0]   divisor,
    output logic            busy,
    output logic            done,
    output logic [DW-1:0]   quotient,
    output logic [DW-1:0]   remainder,
    output logic            div_zero,
    output logic            overflow
);

    localparam int CNT_W = $clog2(DW + 1);

    div_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]   r_q, r_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [DW-1:0]   d_q, d_d;
    logic [DW-1:0]   quotient_q, quotient_d;
    logic [DW-1:0]   remainder_q, remainder_d;
    logic            div_zero_q, div_zero_d;
    logic            overflow_q, overflow_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [DW-1:0]   step_r;
    logic            step_q;

    div_step #(.DW(DW)) u_step (
        .r_in   (r_q),
        .bit_in (shift_q[DW-1]),
        .d_in   (d_q),
        .r_next (step_r),
        .qbit   (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        r_d         = r_q;
        shift_d     = shift_q;
        d_d         = d_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = div_zero_q;
        overflow_d  = overflow_q;

        case (state_q)
            ST_RUN: begin
                r_d     = step_r;
                shift_d = {shift_q[DW-2:0], step_q};
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = ST_DONE;
                    quotient_d  = {shift_q[DW-2:0], step_q};
                    remainder_d = step_r;
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (start) begin
                    if (divisor == '0) begin
                        state_d     = ST_DONE;
                        div_zero_d  = 1'b1;
                        overflow_d  = 1'b0;
                        quotient_d  = '1;
                        remainder_d = dividend[DW-1:0];
                    end else if (dividend[2*DW-1:DW] >= divisor) begin
                        // Quotient would not fit in DW bits.
                        state_d     = ST_DONE;
                        div_zero_d  = 1'b0;
                        overflow_d  = 1'b1;
                        quotient_d  = '1;
                        remainder_d = '0;
                    end else begin
                        state_d    = ST_RUN;
                        div_zero_d = 1'b0;
                        overflow_d = 1'b0;
                        r_d        = dividend[2*DW-1:DW];
                        shift_d    = dividend[DW-1:0];
                        d_d        = divisor;
                        cnt_d      = CNT_W'(DW);
                    end
                end
            end
        endcase

        busy_d = (state_d == ST_RUN);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            r_q         <= '0;
            shift_q     <= '0;
            d_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            r_q         <= r_d;
            shift_q     <= shift_d;
            d_q         <= d_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            div_zero_q  <= div_zero_d;
            overflow_q  <= overflow_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider with DW=8.
module tb_seq_divider;

    localparam int DW = 8;
    localparam int MAX_WAIT = 40;

    logic            clk;
    logic            rst;
    logic            start;
    logic [2*DW-1:0] dividend;
    logic [DW-1:0]   divisor;
    logic            busy;
    logic            done;
    logic [DW-1:0]   quotient;
    logic [DW-1:0]   remainder;
    logic            div_zero;
    logic            overflow;

    int total;
    int bad;

    seq_divider #(.DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        dz;
        logic        ov;
        int          lat;
        int          nbusy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one operation at the next falling edge and waits for done.
    // lat counts rising edges from the accepting edge through the edge that raises done.
    task automatic do_op(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov,
                         output int lat, output int nbusy);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        lat   = 1;
        nbusy = 0;
        @(negedge clk);
        start = 1'b0;
        while (!done && lat < MAX_WAIT) begin
            if (busy) nbusy++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 32'(lat), 32'(MAX_WAIT + 1));
        q  = quotient;
        r  = remainder;
        dz = div_zero;
        ov = overflow;
    endtask

    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic dz, output logic ov, output int lat);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 8'd0) begin
            dz = 1'b1; q = 8'hFF; r = a[7:0]; lat = 1;
        end else if (a[15:8] >= b) begin
            ov = 1'b1; q = 8'hFF; r = 8'h00; lat = 1;
        end else begin
            q = 8'(a / 16'(b)); r = 8'(a % 16'(b)); lat = DW + 1;
        end
    endtask

    vec_t vecs[12];

    initial begin
        logic [7:0] q, r, eq, er;
        logic dz, ov, edz, eov;
        int lat, nbusy, elat, w;

        total = 0;
        bad   = 0;
        rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        vecs[0]  = '{16'd1000,  8'd7,    8'd142, 8'd6,   1'b0, 1'b0, 9, 8};
        vecs[1]  = '{16'd65279, 8'd255,  8'd255, 8'd254, 1'b0, 1'b0, 9, 8};
        vecs[2]  = '{16'h1234,  8'h00,   8'hFF,  8'h34,  1'b1, 1'b0, 1, 0};
        vecs[3]  = '{16'h1234,  8'h10,   8'hFF,  8'h00,  1'b0, 1'b1, 1, 0};
        vecs[4]  = '{16'd50,    8'd5,    8'd10,  8'd0,   1'b0, 1'b0, 9, 8};
        vecs[5]  = '{16'h0100,  8'h03,   8'd85,  8'd1,   1'b0, 1'b0, 9, 8};
        vecs[6]  = '{16'h00FF,  8'h01,   8'hFF,  8'h00,  1'b0, 1'b0, 9, 8};
        vecs[7]  = '{16'h0000,  8'h05,   8'h00,  8'h00,  1'b0, 1'b0, 9, 8};
        vecs[8]  = '{16'h0100,  8'h01,   8'hFF,  8'h00,  1'b0, 1'b1, 1, 0};
        vecs[9]  = '{16'hFFFF,  8'hFF,   8'hFF,  8'h00,  1'b0, 1'b1, 1, 0};
        vecs[10] = '{16'h7FFF,  8'h80,   8'd255, 8'd127, 1'b0, 1'b0, 9, 8};
        vecs[11] = '{16'h0A00,  8'h0B,   8'd232, 8'd8,   1'b0, 1'b0, 9, 8};

        // Reset state
        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_q", 32'(quotient), 0);
        check("rst_r", 32'(remainder), 0);
        check("rst_flags", 32'({div_zero, overflow}), 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].a, vecs[i].b, q, r, dz, ov, lat, nbusy);
            check($sformatf("v%0d_q", i), 32'(q), 32'(vecs[i].q));
            check($sformatf("v%0d_r", i), 32'(r), 32'(vecs[i].r));
            check($sformatf("v%0d_flags", i), 32'({dz, ov}), 32'({vecs[i].dz, vecs[i].ov}));
            check($sformatf("v%0d_lat", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("v%0d_busy", i), 32'(nbusy), 32'(vecs[i].nbusy));
            @(negedge clk);
            check($sformatf("v%0d_done_pulse", i), 32'(done), 0);
            check($sformatf("v%0d_hold_q", i), 32'(quotient), 32'(vecs[i].q));
        end

        // Reset during RUN
        @(negedge clk);
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_busy_before_rst", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_q", 32'(quotient), 0);
        check("mid_rst_r", 32'(remainder), 0);
        check("mid_rst_flags", 32'({div_zero, overflow}), 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle", 32'({busy, done}), 0);
        do_op(16'd50, 8'd5, q, r, dz, ov, lat, nbusy);
        check("post_rst_q", 32'(q), 10);
        check("post_rst_r", 32'(r), 0);
        check("post_rst_lat", 32'(lat), 9);

        // Start held through RUN with changing operands, then back-to-back start from DONE
        @(negedge clk);
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dividend = 16'h0100; divisor = 8'h03;
        w = 1;
        while (!done && w < MAX_WAIT) begin
            @(posedge clk);
            w++;
            @(negedge clk);
        end
        check("hold_lat", 32'(w), 9);
        check("hold_q", 32'(quotient), 142);
        check("hold_r", 32'(remainder), 6);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("b2b_busy", 32'(busy), 1);
        check("b2b_done_low", 32'(done), 0);
        w = 1;
        while (!done && w < MAX_WAIT) begin
            @(posedge clk);
            w++;
            @(negedge clk);
        end
        check("b2b_lat", 32'(w), 9);
        check("b2b_q", 32'(quotient), 85);
        check("b2b_r", 32'(remainder), 1);

        // Randomized sweep against the reference model
        for (int n = 0; n < 2000; n++) begin
            logic [15:0] ra;
            logic [7:0]  rb;
            ra = 16'($urandom);
            case (n % 4)
                0: rb = 8'($urandom);
                1: rb = 8'd0;
                2: begin rb = 8'($urandom_range(1, 255)); ra[15:8] = 8'($urandom_range(0, int'(rb) - 1)); end
                default: begin rb = 8'($urandom_range(1, 255)); ra[15:8] = 8'(int'(rb) - 1); end
            endcase
            model(ra, rb, eq, er, edz, eov, elat);
            do_op(ra, rb, q, r, dz, ov, lat, nbusy);
            check($sformatf("rnd%0d_%0h_%0h", n, ra, rb), {q, r, 6'd0, dz, ov, 8'(lat)},
                  {eq, er, 6'd0, edz, eov, 8'(elat)});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
